// File: rtl/ldtu_word_serializer_pkg.sv
// Shared constants and helpers for the LDTU 32-bit word serializer gearbox.
package ldtu_ser_pkg;

  localparam int          LDTU_NBITS_32     = 32;
  localparam logic [31:0] LDTU_IDLE_PATTERN = 32'h5A5A5A5A;

  function automatic int beats(input int out_w);
    return LDTU_NBITS_32 / out_w;
  endfunction

  // Slice idx of a word in transmission order, right-aligned in the result.
  function automatic logic [31:0] slice_sel(input logic [31:0] word, input int idx,
                                            input int out_w, input bit msb_first);
    logic [31:0] mask;
    mask = (32'd1 << out_w) - 32'd1;
    if (msb_first) return (word >> (LDTU_NBITS_32 - (idx + 1) * out_w)) & mask;
    else           return (word >> (idx * out_w)) & mask;
  endfunction

endpackage

// File: rtl/ldtu_word_serializer_if.sv
// Word-in / slice-out bus of the LDTU serializer; DOUT_PARITY exists only with LDTU_SER_PARITY_EN.
interface ldtu_word_serializer_if #(parameter int OUT_W = 8);
  import ldtu_ser_pkg::*;

  logic [LDTU_NBITS_32-1:0] DIN;
  logic                     DIN_VALID;
  logic                     DIN_READY;
  logic                     SER_EN;
  logic [OUT_W-1:0]         DOUT;
  logic                     DOUT_FIRST;
  logic                     DOUT_IDLE;
  logic [1:0]               BUF_LEVEL;
  logic                     OVERFLOW;
`ifdef LDTU_SER_PARITY_EN
  logic                     DOUT_PARITY;

  modport master (output DIN, DIN_VALID, SER_EN,
                  input  DIN_READY, DOUT, DOUT_FIRST, DOUT_IDLE, BUF_LEVEL, OVERFLOW, DOUT_PARITY);
  modport slave  (input  DIN, DIN_VALID, SER_EN,
                  output DIN_READY, DOUT, DOUT_FIRST, DOUT_IDLE, BUF_LEVEL, OVERFLOW, DOUT_PARITY);
`else
  modport master (output DIN, DIN_VALID, SER_EN,
                  input  DIN_READY, DOUT, DOUT_FIRST, DOUT_IDLE, BUF_LEVEL, OVERFLOW);
  modport slave  (input  DIN, DIN_VALID, SER_EN,
                  output DIN_READY, DOUT, DOUT_FIRST, DOUT_IDLE, BUF_LEVEL, OVERFLOW);
`endif

endinterface

// File: rtl/ldtu_word_serializer_fifo2.sv
// Two-entry 32-bit FIFO buffering link words ahead of the serializer shift register.
module ldtu_ser_fifo2
  import ldtu_ser_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [LDTU_NBITS_32-1:0] din,
  input  logic                     pop,
  output logic [LDTU_NBITS_32-1:0] head,
  output logic [1:0]               level
);

  logic [LDTU_NBITS_32-1:0] mem_q [2];
  logic [LDTU_NBITS_32-1:0] mem_d [2];
  logic                     rd_ptr_q, rd_ptr_d;
  logic                     wr_ptr_q, wr_ptr_d;
  logic [1:0]               level_q, level_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q ^ pop;
    wr_ptr_d = wr_ptr_q ^ push;
    level_d  = level_q;
    if (push) mem_d[wr_ptr_q] = din;
    case ({push, pop})
      2'b10:   level_d = level_q + 2'd1;
      2'b01:   level_d = level_q - 2'd1;
      default: level_d = level_q;
    endcase
  end

  // Storage carries no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      level_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/ldtu_word_serializer.sv
// 32-bit word to OUT_W-bit slice gearbox with idle fill; LDTU_SER_PARITY_EN adds DOUT_PARITY.
module ldtu_word_serializer
  import ldtu_ser_pkg::*;
#(
  parameter int          OUT_W        = 8,
  parameter logic [31:0] IDLE_PATTERN = LDTU_IDLE_PATTERN,
  parameter bit          MSB_FIRST    = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  ldtu_word_serializer_if.slave bus
);

  localparam int BEATS = beats(OUT_W);
  localparam int CNT_W = $clog2(BEATS);

  if (OUT_W != 1 && OUT_W != 2 && OUT_W != 4 && OUT_W != 8 && OUT_W != 16) begin : g_bad_out_w
    $error("ldtu_word_serializer: OUT_W must be one of 1,2,4,8,16");
  end

  logic [LDTU_NBITS_32-1:0] fifo_head;
  logic [1:0]               fifo_level;
  logic                     din_ready, push, pop, load;

  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     active_q, active_d;
  logic [LDTU_NBITS_32-1:0] shift_q, shift_d;
  logic [OUT_W-1:0]         dout_q, dout_d;
  logic                     first_q, first_d;
  logic                     idle_q, idle_d;
  logic                     ovf_q, ovf_d;
  logic [LDTU_NBITS_32-1:0] load_word;

  assign din_ready = (fifo_level != 2'd2);
  assign push      = bus.DIN_VALID & din_ready;
  // Parked (no word in flight) counts as a load opportunity on every edge.
  assign load      = !active_q || (cnt_q == CNT_W'(BEATS - 1));

  ldtu_ser_fifo2 u_fifo (
    .clk   (CLK),
    .rst_n (RST),
    .push  (push),
    .din   (bus.DIN),
    .pop   (pop),
    .head  (fifo_head),
    .level (fifo_level)
  );

  always_comb begin
    cnt_d     = cnt_q;
    active_d  = active_q;
    shift_d   = shift_q;
    dout_d    = dout_q;
    first_d   = first_q;
    idle_d    = idle_q;
    ovf_d     = ovf_q | (bus.DIN_VALID & ~din_ready);
    pop       = 1'b0;
    load_word = IDLE_PATTERN;
    if (load) begin
      cnt_d = '0;
      if (bus.SER_EN) begin
        // Level before the edge decides: a word pushed on this same edge waits a period.
        if (fifo_level != 2'd0) begin
          pop       = 1'b1;
          load_word = fifo_head;
        end
        active_d = 1'b1;
        shift_d  = load_word;
        dout_d   = OUT_W'(slice_sel(load_word, 0, OUT_W, MSB_FIRST));
        first_d  = 1'b1;
        idle_d   = ~pop;
      end else begin
        active_d = 1'b0;
        dout_d   = '0;
        first_d  = 1'b0;
        idle_d   = 1'b1;
      end
    end else begin
      cnt_d   = cnt_q + CNT_W'(1);
      shift_d = MSB_FIRST ? (shift_q << OUT_W) : (shift_q >> OUT_W);
      dout_d  = OUT_W'(slice_sel(shift_q, 1, OUT_W, MSB_FIRST));
      first_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      shift_q  <= IDLE_PATTERN;
      dout_q   <= '0;
      first_q  <= 1'b0;
      idle_q   <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      shift_q  <= shift_d;
      dout_q   <= dout_d;
      first_q  <= first_d;
      idle_q   <= idle_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.DIN_READY  = din_ready;
  assign bus.DOUT       = dout_q;
  assign bus.DOUT_FIRST = first_q;
  assign bus.DOUT_IDLE  = idle_q;
  assign bus.BUF_LEVEL  = fifo_level;
  assign bus.OVERFLOW   = ovf_q;

`ifdef LDTU_SER_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (load) par_d = pop ? ^fifo_head : 1'b0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) par_q <= 1'b0;
    else      par_q <= par_d;
  end

  assign bus.DOUT_PARITY = par_q;
`endif

endmodule
